serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; the block SHALL support any WIDTH >= 2.
REQ-002 Parameter EARLY_EXIT, default 1: 1 means stop at the first differing bit; 0 means always scan all WIDTH bits (constant time).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to compare; accepted only in IDLE.
REQ-006 signed_mode  input  1  operands are two's complement when 1 and unsigned when 0; sampled with start.
REQ-007 a  input  WIDTH  operand A; sampled on the accepting edge.
REQ-008 b  input  WIDTH  operand B; sampled on the accepting edge.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse when the result flags update.
REQ-011 a_greater  output  1  result flag: A > B.
REQ-012 a_equal  output  1  result flag: A == B.
REQ-013 a_less  output  1  result flag: A < B.

Function
REQ-014 FSM states SHALL be IDLE, SCAN and FINISH.
- IDLE->SCAN on start.
- SCAN->FINISH on decision.
- FINISH->IDLE unconditionally.
REQ-015 In IDLE with start=1, the block SHALL register a, b and signed_mode, load the bit index to WIDTH-1, and set busy=1 on the same edge.
REQ-016 In SCAN, the block SHALL examine one bit per cycle, MSB first, decrementing the index each cycle.
REQ-017 A decision SHALL occur:
- at the first bit where A and B differ, if EARLY_EXIT=1; or
- at index 0, in all cases.
REQ-018 On decision, the block SHALL latch the result flags exactly one-hot and enter FINISH; in FINISH, done=1 and busy=0.
REQ-019 Result rules:
- Differing bit below the MSB: the operand holding 1 is greater.
- Differing MSB, unsigned mode: the operand holding 1 is greater.
- Differing MSB, signed mode: the operand holding 1 is less.
- No differing bit: a_equal=1.
REQ-020 With EARLY_EXIT=0, the block SHALL record the first differing bit and ignore all later bits, so the result equals the EARLY_EXIT=1 result.
REQ-021 Latency SHALL be counted from the accepting edge to the edge that raises done:
- EARLY_EXIT=1: K+1 cycles, where K (1..WIDTH) is the number of bits examined.
- EARLY_EXIT=0: always WIDTH+1 cycles.
REQ-022 start while busy=1 or in FINISH SHALL be ignored, and input changes during a comparison SHALL have no effect.
REQ-023 start=1 in the IDLE cycle that follows FINISH SHALL be accepted (back-to-back operation).
REQ-024 The result flags SHALL hold their value until the next decision and SHALL NOT clear when a new start is accepted.
REQ-025 The bit index SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.

Reset
REQ-026 rst_n=0 SHALL force, at any time including mid-scan:
- state=IDLE;
- busy=0, done=0;
- a_greater=0, a_equal=0, a_less=0 (no valid result);
- index=WIDTH-1, operand registers=0.
REQ-027 The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-028 Package cmp_pkg SHALL hold the state enum (IDLE, SCAN, FINISH) and the result encoding constants (GT, EQ, LT).
REQ-029 The block SHALL be a single module with no sub-module; the per-bit decision logic is inline combinational logic.

Verification
REQ-030 The bench SHALL cover these directed scenarios at WIDTH=8:
- EARLY_EXIT=1, unsigned, a=3, b=5 -> done 7 cycles after the accepting edge, a_less=1.
- EARLY_EXIT=1, a=7, b=7 -> done 9 cycles after the accepting edge, a_equal=1.
- a=0xFF, b=0x01 -> signed: done after 2 cycles, a_less=1; unsigned: done after 2 cycles, a_greater=1.
- EARLY_EXIT=0, unsigned, a=10, b=4 -> done after 9 cycles, a_greater=1.
- Pulse start again while busy -> ignored; the first result stands.
- rst_n=0 at cycle 3 of a scan -> all outputs 0, state IDLE; a new comparison then completes correctly.
REQ-031 The bench SHALL check each scenario with a self-checking assertion that flags are one-hot after done and that done is exactly one cycle wide.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and the
// pending-result encoding carried while scanning.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } res_e;

endpackage

// File: rtl/serial_comparator.sv
// Bit-serial, MSB-first magnitude comparator with optional early exit and
// signed/unsigned operand interpretation. Result flags are one-hot and sticky.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_greater,
  output logic             a_equal,
  output logic             a_less
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             signed_q, signed_d;
  logic [IW-1:0]    idx_q, idx_d;
  res_e             res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic             diff_c;
  res_e             bit_res_c;
  res_e             res_now_c;
  logic             decide_c;

  // Per-bit decision: the first differing bit fixes the result; later bits are ignored.
  always_comb begin
    diff_c = a_q[idx_q] ^ b_q[idx_q];
    if (signed_q && (idx_q == IDX_TOP)) begin
      bit_res_c = a_q[idx_q] ? LT : GT;
    end else begin
      bit_res_c = a_q[idx_q] ? GT : LT;
    end
    res_now_c = ((res_q == EQ) && diff_c) ? bit_res_c : res_q;
    decide_c  = (idx_q == '0) || (EARLY_EXIT && diff_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          idx_d    = IDX_TOP;
          res_d    = EQ;
          busy_d   = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        res_d = res_now_c;
        if (decide_c) begin
          gt_d    = (res_now_c == GT);
          eq_d    = (res_now_c == EQ);
          lt_d    = (res_now_c == LT);
          state_d = FINISH;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      // Outputs are registered, so done rises on the edge that leaves FINISH.
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= IDX_TOP;
      res_q    <= EQ;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign a_greater = gt_q;
  assign a_equal   = eq_q;
  assign a_less    = lt_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator at WIDTH=8 with both EARLY_EXIT settings.
module tb_serial_comparator;

  localparam logic [2:0] F_GT   = 3'b100;
  localparam logic [2:0] F_EQ   = 3'b010;
  localparam logic [2:0] F_LT   = 3'b001;
  localparam logic [2:0] F_NONE = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_e1, start_e0;
  logic       sm;
  logic [7:0] a, b;
  logic       busy1, done1, gt1, eq1, lt1;
  logic       busy0, done0, gt0, eq0, lt0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_e1 (
    .clk(clk), .rst_n(rst_n), .start(start_e1), .signed_mode(sm), .a(a), .b(b),
    .busy(busy1), .done(done1), .a_greater(gt1), .a_equal(eq1), .a_less(lt1)
  );

  serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_e0 (
    .clk(clk), .rst_n(rst_n), .start(start_e0), .signed_mode(sm), .a(a), .b(b),
    .busy(busy0), .done(done0), .a_greater(gt0), .a_equal(eq0), .a_less(lt0)
  );

  function automatic logic get_busy(bit ee);
    return ee ? busy1 : busy0;
  endfunction

  function automatic logic get_done(bit ee);
    return ee ? done1 : done0;
  endfunction

  function automatic logic [2:0] get_flags(bit ee);
    return ee ? {gt1, eq1, lt1} : {gt0, eq0, lt0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands, pulse start across one edge and check the accept.
  task automatic start_cmp(input bit ee, input logic [7:0] av, input logic [7:0] bv,
                           input bit s, input logic [2:0] prev);
    a  = av;
    b  = bv;
    sm = s;
    if (ee) start_e1 = 1'b1; else start_e0 = 1'b1;
    @(posedge clk); #1;
    start_e1 = 1'b0;
    start_e0 = 1'b0;
    chk("accept_busy", 32'(get_busy(ee)), 32'd1);
    chk("accept_done_low", 32'(get_done(ee)), 32'd0);
    chk("flags_held", 32'(get_flags(ee)), 32'(prev));
  endtask

  // Count edges from the accept to done; optionally disturb inputs mid-scan.
  task automatic wait_done(input bit ee, input int exp_lat, input logic [2:0] exp_f,
                           input bit disturb);
    int lat  = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (disturb && i == 2) begin
        a  = 8'h00;
        b  = 8'hFF;
        sm = 1'b1;
        if (ee) start_e1 = 1'b1; else start_e0 = 1'b1;
      end
      if (disturb && i == 3) begin
        start_e1 = 1'b0;
        start_e0 = 1'b0;
      end
      if (get_done(ee)) seen = 1'b1;
    end
    start_e1 = 1'b0;
    start_e0 = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("flags", 32'(get_flags(ee)), 32'(exp_f));
    chk("onehot", 32'($countones(get_flags(ee))), 32'd1);
    chk("busy_low_at_done", 32'(get_busy(ee)), 32'd0);
  endtask

  task automatic idle_check(input bit ee);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(get_done(ee)), 32'd0);
    chk("idle_busy", 32'(get_busy(ee)), 32'd0);
  endtask

  task automatic reset_check(input bit ee);
    chk("rst_busy", 32'(get_busy(ee)), 32'd0);
    chk("rst_done", 32'(get_done(ee)), 32'd0);
    chk("rst_flags", 32'(get_flags(ee)), 32'(F_NONE));
  endtask

  initial begin
    rst_n    = 1'b0;
    start_e1 = 1'b0;
    start_e0 = 1'b0;
    sm       = 1'b0;
    a        = '0;
    b        = '0;
    #12;
    reset_check(1'b1);
    reset_check(1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Early exit, unsigned 3 vs 5: differs at bit 2, six bits examined.
    start_cmp(1'b1, 8'd3, 8'd5, 1'b0, F_NONE);
    wait_done(1'b1, 7, F_LT, 1'b0);
    idle_check(1'b1);

    // Equal operands scan all bits.
    start_cmp(1'b1, 8'd7, 8'd7, 1'b0, F_LT);
    wait_done(1'b1, 9, F_EQ, 1'b0);
    idle_check(1'b1);

    // MSB differs: signed makes 0xFF the smaller operand.
    start_cmp(1'b1, 8'hFF, 8'h01, 1'b1, F_EQ);
    wait_done(1'b1, 2, F_LT, 1'b0);
    idle_check(1'b1);

    // Same operands unsigned, then a back-to-back start in the done cycle.
    start_cmp(1'b1, 8'hFF, 8'h01, 1'b0, F_LT);
    wait_done(1'b1, 2, F_GT, 1'b0);
    start_cmp(1'b1, 8'd3, 8'd5, 1'b0, F_GT);
    wait_done(1'b1, 7, F_LT, 1'b0);
    idle_check(1'b1);

    // Signed -128 vs 127, and -2 vs -1 (differs only at bit 0).
    start_cmp(1'b1, 8'h80, 8'h7F, 1'b1, F_LT);
    wait_done(1'b1, 2, F_LT, 1'b0);
    idle_check(1'b1);
    start_cmp(1'b1, 8'hFE, 8'hFF, 1'b1, F_LT);
    wait_done(1'b1, 9, F_LT, 1'b0);
    idle_check(1'b1);

    // Constant-time instance always takes WIDTH+1 cycles.
    start_cmp(1'b0, 8'd10, 8'd4, 1'b0, F_NONE);
    wait_done(1'b0, 9, F_GT, 1'b0);
    idle_check(1'b0);
    start_cmp(1'b0, 8'hFF, 8'h01, 1'b1, F_GT);
    wait_done(1'b0, 9, F_LT, 1'b0);
    idle_check(1'b0);
    start_cmp(1'b0, 8'd7, 8'd7, 1'b0, F_LT);
    wait_done(1'b0, 9, F_EQ, 1'b0);
    idle_check(1'b0);

    // Start and operand changes while busy are ignored: 0x0A vs 0x04 differs at bit 3.
    start_cmp(1'b1, 8'h0A, 8'h04, 1'b0, F_LT);
    wait_done(1'b1, 6, F_GT, 1'b1);
    idle_check(1'b1);

    // Reset in the middle of a scan, then a clean comparison.
    start_cmp(1'b1, 8'd7, 8'd7, 1'b0, F_GT);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    reset_check(1'b1);
    reset_check(1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    start_cmp(1'b1, 8'd3, 8'd5, 1'b0, F_NONE);
    wait_done(1'b1, 7, F_LT, 1'b0);
    idle_check(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
